// File: rtl/pim_activity_counter.sv
// Two-stage activity counter for PIM packet streams: classifies each accepted
// packet by its nonzero lanes and keeps saturating activity totals with snapshots.
module pim_activity_counter #(
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned LANE_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  enable,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    input  logic                  snap_req,
    input  logic                  snap_ack,
    output logic                  snap_valid,
    output logic [CNT_WIDTH-1:0]  active_cycles_out,
    output logic [CNT_WIDTH-1:0]  idle_cycles_out,
    output logic [CNT_WIDTH-1:0]  total_ops_out,
    output logic [CNT_WIDTH-1:0]  active_lanes_out,
    output logic                  sat_flag
);

    localparam int unsigned NUM_LANES = DATA_WIDTH / LANE_WIDTH;
    localparam int unsigned POP_WIDTH = $clog2(NUM_LANES + 1);
    localparam int unsigned SUM_WIDTH = ((CNT_WIDTH > POP_WIDTH) ? CNT_WIDTH : POP_WIDTH) + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DRAIN = 2'd2,
        SNAP  = 2'd3
    } state_t;

    state_t state;

    logic                 accept_c;
    logic [NUM_LANES-1:0] lane_nz_c;
    logic [POP_WIDTH-1:0] pop_c;

    logic                 s1_valid;
    logic                 s1_last;
    logic [NUM_LANES-1:0] s1_flags;

    logic                 s2_valid;
    logic                 s2_last;
    logic                 s2_active;
    logic [POP_WIDTH-1:0] s2_pop;

    logic                 act_inc_c;
    logic                 idle_inc_c;
    logic                 ops_inc_c;
    logic [SUM_WIDTH-1:0] lanes_sum_c;
    logic                 lanes_ovf_c;
    logic                 sat_hit_c;

    assign in_ready = enable && (state == COUNT);
    assign accept_c = in_valid && in_ready;

    // Per-lane nonzero detection on the incoming payload
    always_comb begin
        lane_nz_c = '0;
        for (int i = 0; i < int'(NUM_LANES); i++) begin
            lane_nz_c[i] = |in_data[i*LANE_WIDTH +: LANE_WIDTH];
        end
    end

    always_comb begin
        pop_c = '0;
        for (int i = 0; i < int'(NUM_LANES); i++) begin
            pop_c = pop_c + POP_WIDTH'(s1_flags[i]);
        end
    end

    // Pipeline; clear drops whatever is in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_flags  <= '0;
            s2_valid  <= 1'b0;
            s2_last   <= 1'b0;
            s2_active <= 1'b0;
            s2_pop    <= '0;
        end else begin
            s1_valid  <= accept_c && !clear;
            s1_last   <= in_last;
            s1_flags  <= lane_nz_c;
            s2_valid  <= s1_valid && !clear;
            s2_last   <= s1_last;
            s2_active <= |s1_flags;
            s2_pop    <= pop_c;
        end
    end

    // Increment requests and overflow detection for the retiring packet
    always_comb begin
        act_inc_c   = s2_valid && s2_active;
        idle_inc_c  = s2_valid && !s2_active;
        ops_inc_c   = s2_valid && s2_last;
        lanes_sum_c = SUM_WIDTH'(active_lanes_out) + SUM_WIDTH'(s2_pop);
        lanes_ovf_c = s2_valid && (lanes_sum_c > SUM_WIDTH'(CNT_MAX));
        sat_hit_c   = (act_inc_c  && (active_cycles_out == CNT_MAX))
                   || (idle_inc_c && (idle_cycles_out   == CNT_MAX))
                   || (ops_inc_c  && (total_ops_out     == CNT_MAX))
                   || lanes_ovf_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_cycles_out <= '0;
            idle_cycles_out   <= '0;
            total_ops_out     <= '0;
            active_lanes_out  <= '0;
            sat_flag          <= 1'b0;
        end else if (clear) begin
            active_cycles_out <= '0;
            idle_cycles_out   <= '0;
            total_ops_out     <= '0;
            active_lanes_out  <= '0;
            sat_flag          <= 1'b0;
        end else begin
            if (act_inc_c && (active_cycles_out != CNT_MAX)) begin
                active_cycles_out <= active_cycles_out + CNT_WIDTH'(1);
            end
            if (idle_inc_c && (idle_cycles_out != CNT_MAX)) begin
                idle_cycles_out <= idle_cycles_out + CNT_WIDTH'(1);
            end
            if (ops_inc_c && (total_ops_out != CNT_MAX)) begin
                total_ops_out <= total_ops_out + CNT_WIDTH'(1);
            end
            if (s2_valid) begin
                active_lanes_out <= lanes_ovf_c ? CNT_MAX : CNT_WIDTH'(lanes_sum_c);
            end
            sat_flag <= sat_flag | sat_hit_c;
        end
    end

    // Control FSM; snap_valid is registered alongside the SNAP state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            snap_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= COUNT;
                    end
                end
                COUNT: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (snap_req) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!s1_valid && !s2_valid) begin
                        state      <= SNAP;
                        snap_valid <= 1'b1;
                    end
                end
                SNAP: begin
                    if (snap_ack) begin
                        state      <= enable ? COUNT : IDLE;
                        snap_valid <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    snap_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pim_activity_counter.sv
// Randomized bench for pim_activity_counter: a default-width instance for function
// and a 4-bit-counter instance for saturation, both against a behavioural model.
`timescale 1ns/1ps
module tb_pim_activity_counter;

    localparam int unsigned DW  = 512;
    localparam int unsigned LW  = 32;
    localparam int unsigned NL  = DW / LW;
    localparam int unsigned CW  = 32;
    localparam int unsigned SCW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, clear, enable, in_valid, in_last, snap_req, snap_ack;
    logic [DW-1:0] in_data;
    logic          in_ready, snap_valid, sat_flag;
    logic [CW-1:0] active_cycles, idle_cycles, total_ops, active_lanes;

    logic           s_clear, s_enable, s_valid, s_last;
    logic [DW-1:0]  s_data;
    logic           s_ready, s_snap_valid, s_sat;
    logic [SCW-1:0] s_active, s_idle, s_ops, s_lanes;

    int errors = 0;
    int checks = 0;

    longint m_act[2], m_idl[2], m_ops[2], m_lan[2], m_max[2];
    bit     m_sat[2];

    pim_activity_counter dut (
        .clk(clk), .rst(rst), .clear(clear), .enable(enable),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .snap_req(snap_req), .snap_ack(snap_ack), .snap_valid(snap_valid),
        .active_cycles_out(active_cycles), .idle_cycles_out(idle_cycles),
        .total_ops_out(total_ops), .active_lanes_out(active_lanes), .sat_flag(sat_flag)
    );

    pim_activity_counter #(.DATA_WIDTH(DW), .LANE_WIDTH(LW), .CNT_WIDTH(SCW)) dut_s (
        .clk(clk), .rst(rst), .clear(s_clear), .enable(s_enable),
        .in_valid(s_valid), .in_ready(s_ready), .in_data(s_data), .in_last(s_last),
        .snap_req(1'b0), .snap_ack(1'b0), .snap_valid(s_snap_valid),
        .active_cycles_out(s_active), .idle_cycles_out(s_idle),
        .total_ops_out(s_ops), .active_lanes_out(s_lanes), .sat_flag(s_sat)
    );

    function automatic int lanes_nz(input logic [DW-1:0] d);
        int n = 0;
        for (int i = 0; i < int'(NL); i++) begin
            if (d[i*LW +: LW] != '0) n++;
        end
        return n;
    endfunction

    function automatic logic [DW-1:0] rand_pkt();
        logic [DW-1:0] v = '0;
        if ($urandom_range(0, 3) == 0) return v;
        for (int i = 0; i < int'(NL); i++) begin
            if ($urandom_range(0, 1) == 1) v[i*LW +: LW] = $urandom;
        end
        return v;
    endfunction

    function automatic longint sat_add(input int u, input longint cur, input longint inc);
        if (cur + inc > m_max[u]) begin
            m_sat[u] = 1'b1;
            return m_max[u];
        end
        return cur + inc;
    endfunction

    function automatic void model_pkt(input int u, input logic [DW-1:0] d, input logic last);
        int n = lanes_nz(d);
        if (n != 0) m_act[u] = sat_add(u, m_act[u], 1);
        else        m_idl[u] = sat_add(u, m_idl[u], 1);
        m_lan[u] = sat_add(u, m_lan[u], longint'(n));
        if (last) m_ops[u] = sat_add(u, m_ops[u], 1);
    endfunction

    function automatic void model_clear(input int u);
        m_act[u] = 0; m_idl[u] = 0; m_ops[u] = 0; m_lan[u] = 0; m_sat[u] = 1'b0;
    endfunction

    function automatic logic [4*CW:0] exp_main();
        return {CW'(m_act[0]), CW'(m_idl[0]), CW'(m_ops[0]), CW'(m_lan[0]), m_sat[0]};
    endfunction

    function automatic logic [4*SCW:0] exp_sat();
        return {SCW'(m_act[1]), SCW'(m_idl[1]), SCW'(m_ops[1]), SCW'(m_lan[1]), m_sat[1]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_last = 1'b0; in_data = '0; snap_req = 1'b0; snap_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1;
        repeat (2) tick();
        checks++;
        if ({active_cycles, idle_cycles, total_ops, active_lanes, sat_flag} !== '0) begin
            errors++;
            $display("FAIL reset_counters: got %h expected 0",
                     {active_cycles, idle_cycles, total_ops, active_lanes, sat_flag});
        end
        checks++;
        if ({in_ready, snap_valid, s_ready, s_snap_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_handshake: got %b expected 0000",
                     {in_ready, snap_valid, s_ready, s_snap_valid});
        end
    endtask

    task automatic test_basic();
        logic [DW-1:0] p[4];
        rst = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL basic_ready: got %b expected 1", in_ready);
        end
        p[0] = '0;
        p[1] = '0; p[1][31:0] = 32'd5;
        p[2] = '0;
        for (int i = 0; i < int'(NL); i++) p[2][i*LW +: LW] = 32'd1;
        p[3] = '0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_data = p[k]; in_last = (k == 3);
            model_pkt(0, p[k], in_last);
            tick();
            if (k == 1) begin
                checks++;
                if ({active_cycles, idle_cycles, total_ops, active_lanes} !== '0) begin
                    errors++;
                    $display("FAIL basic_latency1: got %h expected 0",
                             {active_cycles, idle_cycles, total_ops, active_lanes});
                end
            end
            if (k == 2) begin
                checks++;
                if ({active_cycles, idle_cycles, total_ops, active_lanes} !== {32'd0, 32'd1, 32'd0, 32'd0}) begin
                    errors++;
                    $display("FAIL basic_latency2: got %h expected idle=1 only",
                             {active_cycles, idle_cycles, total_ops, active_lanes});
                end
            end
        end
        idle_inputs();
        repeat (3) tick();
        checks++;
        if ({active_cycles, idle_cycles, total_ops, active_lanes, sat_flag} !==
            {32'd2, 32'd2, 32'd1, 32'd17, 1'b0}) begin
            errors++;
            $display("FAIL basic_totals: got act=%0d idle=%0d ops=%0d lanes=%0d sat=%b expected 2 2 1 17 0",
                     active_cycles, idle_cycles, total_ops, active_lanes, sat_flag);
        end
    endtask

    task automatic test_random();
        int bad_ready = 0;
        for (int c = 0; c < 60; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = rand_pkt();
            in_last  = ($urandom_range(0, 3) == 0);
            #1;
            if (in_ready !== 1'b1) bad_ready++;
            if (in_valid) model_pkt(0, in_data, in_last);
            tick();
        end
        idle_inputs();
        repeat (3) tick();
        checks++;
        if (bad_ready != 0) begin
            errors++; $display("FAIL random_ready: got %0d low cycles expected 0", bad_ready);
        end
        checks++;
        if ({active_cycles, idle_cycles, total_ops, active_lanes, sat_flag} !== exp_main()) begin
            errors++;
            $display("FAIL random_totals: got %h expected %h",
                     {active_cycles, idle_cycles, total_ops, active_lanes, sat_flag}, exp_main());
        end
    endtask

    task automatic test_snapshot();
        logic [4*CW:0] frozen;
        int n;
        in_valid = 1'b1; in_data = rand_pkt(); in_last = 1'b1;
        model_pkt(0, in_data, in_last);
        tick();
        in_data = rand_pkt(); in_last = 1'b0; snap_req = 1'b1;
        model_pkt(0, in_data, in_last);
        tick();
        snap_req = 1'b0; in_data = rand_pkt();
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL snap_ready_drop: got %b expected 0", in_ready);
        end
        n = 0;
        while (n < 10 && snap_valid !== 1'b1) begin
            in_data = rand_pkt();
            tick();
            n++;
        end
        checks++;
        if (snap_valid !== 1'b1) begin
            errors++; $display("FAIL snap_timeout: snap_valid=%b expected 1 within 10 cycles", snap_valid);
        end
        checks++;
        if ({active_cycles, idle_cycles, total_ops, active_lanes, sat_flag} !== exp_main()) begin
            errors++;
            $display("FAIL snap_counts: got %h expected %h",
                     {active_cycles, idle_cycles, total_ops, active_lanes, sat_flag}, exp_main());
        end
        frozen = exp_main();
        for (int k = 0; k < 3; k++) begin
            snap_req = 1'b1; in_data = rand_pkt();
            tick();
            checks++;
            if ({active_cycles, idle_cycles, total_ops, active_lanes, sat_flag, snap_valid, in_ready} !==
                {frozen, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL snap_frozen: got %h valid=%b ready=%b expected %h valid=1 ready=0",
                         {active_cycles, idle_cycles, total_ops, active_lanes, sat_flag},
                         snap_valid, in_ready, frozen);
            end
        end
        snap_req = 1'b0; in_valid = 1'b0; snap_ack = 1'b1;
        tick();
        snap_ack = 1'b0;
        checks++;
        if ({snap_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL snap_release: got valid=%b ready=%b expected valid=0 ready=1", snap_valid, in_ready);
        end
    endtask

    task automatic test_clear_retire();
        in_valid = 1'b1; in_data = rand_pkt(); in_data[3*LW] = 1'b1; in_last = 1'b1;
        tick();
        in_data = rand_pkt(); in_data[5*LW] = 1'b1;
        tick();
        idle_inputs();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_clear(0);
        checks++;
        if ({active_cycles, idle_cycles, total_ops, active_lanes, sat_flag} !== '0) begin
            errors++;
            $display("FAIL clear_wins: got %h expected 0",
                     {active_cycles, idle_cycles, total_ops, active_lanes, sat_flag});
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL clear_state: in_ready got %b expected 1", in_ready);
        end
        repeat (3) tick();
        checks++;
        if ({active_cycles, idle_cycles, total_ops, active_lanes, sat_flag} !== exp_main()) begin
            errors++;
            $display("FAIL clear_flush: got %h expected %h",
                     {active_cycles, idle_cycles, total_ops, active_lanes, sat_flag}, exp_main());
        end
    endtask

    task automatic test_reset_midflight();
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_data = rand_pkt(); in_data[0] = 1'b1; in_last = 1'b1;
            tick();
        end
        idle_inputs();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({active_cycles, idle_cycles, total_ops, active_lanes, sat_flag, in_ready, snap_valid} !== '0) begin
            errors++;
            $display("FAIL rst_async: got %h ready=%b snap=%b expected all 0",
                     {active_cycles, idle_cycles, total_ops, active_lanes, sat_flag}, in_ready, snap_valid);
        end
        repeat (2) tick();
        rst = 1'b0;
        model_clear(0);
        model_clear(1);
        repeat (4) tick();
        checks++;
        if ({active_cycles, idle_cycles, total_ops, active_lanes, sat_flag} !== exp_main()) begin
            errors++;
            $display("FAIL rst_discard: got %h expected %h",
                     {active_cycles, idle_cycles, total_ops, active_lanes, sat_flag}, exp_main());
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL rst_resume: in_ready got %b expected 1", in_ready);
        end
    endtask

    task automatic test_disable();
        int bad_ready = 0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; in_data = rand_pkt(); in_last = 1'b0;
            model_pkt(0, in_data, in_last);
            tick();
        end
        idle_inputs();
        repeat (3) tick();
        enable = 1'b0; in_valid = 1'b1; in_data = rand_pkt(); in_data[7*LW] = 1'b1; in_last = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL disable_ready: got %b expected 0", in_ready);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            if (in_ready !== 1'b0) bad_ready++;
        end
        checks++;
        if (bad_ready != 0) begin
            errors++; $display("FAIL disable_hold: got %0d ready cycles expected 0", bad_ready);
        end
        checks++;
        if ({active_cycles, idle_cycles, total_ops, active_lanes, sat_flag} !== exp_main()) begin
            errors++;
            $display("FAIL disable_counts: got %h expected %h",
                     {active_cycles, idle_cycles, total_ops, active_lanes, sat_flag}, exp_main());
        end
        idle_inputs();
        enable = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_saturation();
        logic [DW-1:0] one_lane = '0;
        logic [DW-1:0] full = '0;
        one_lane[0] = 1'b1;
        for (int i = 0; i < int'(NL); i++) full[i*LW] = 1'b1;
        s_clear = 1'b1; tick(); s_clear = 1'b0;
        model_clear(1);
        checks++;
        if (s_ready !== 1'b1) begin
            errors++; $display("FAIL sat_ready: got %b expected 1", s_ready);
        end
        for (int k = 0; k < 14; k++) begin
            s_valid = 1'b1; s_data = one_lane; s_last = 1'b0;
            model_pkt(1, s_data, s_last);
            tick();
        end
        s_valid = 1'b0; repeat (3) tick();
        checks++;
        if ({s_active, s_idle, s_ops, s_lanes, s_sat} !== {4'd14, 4'd0, 4'd0, 4'd14, 1'b0}) begin
            errors++;
            $display("FAIL sat_preload: got act=%0d lanes=%0d sat=%b expected 14 14 0", s_active, s_lanes, s_sat);
        end
        for (int k = 0; k < 3; k++) begin
            s_valid = 1'b1; s_data = one_lane;
            model_pkt(1, s_data, s_last);
            tick();
        end
        s_valid = 1'b0; repeat (3) tick();
        checks++;
        if ({s_active, s_idle, s_ops, s_lanes, s_sat} !== {4'd15, 4'd0, 4'd0, 4'd15, 1'b1}) begin
            errors++;
            $display("FAIL sat_limit: got act=%0d lanes=%0d sat=%b expected 15 15 1", s_active, s_lanes, s_sat);
        end
        for (int k = 0; k < 24; k++) begin
            s_valid = 1'($urandom_range(0, 1)); s_data = rand_pkt(); s_last = 1'($urandom_range(0, 1));
            if (s_valid) model_pkt(1, s_data, s_last);
            tick();
        end
        s_valid = 1'b0; s_last = 1'b0; repeat (3) tick();
        checks++;
        if ({s_active, s_idle, s_ops, s_lanes, s_sat} !== exp_sat()) begin
            errors++;
            $display("FAIL sat_random: got %h expected %h", {s_active, s_idle, s_ops, s_lanes, s_sat}, exp_sat());
        end
        s_clear = 1'b1; tick(); s_clear = 1'b0;
        model_clear(1);
        checks++;
        if ({s_active, s_idle, s_ops, s_lanes, s_sat} !== '0) begin
            errors++;
            $display("FAIL sat_clear: got %h expected 0", {s_active, s_idle, s_ops, s_lanes, s_sat});
        end
        s_valid = 1'b1; s_data = full;
        model_pkt(1, s_data, s_last);
        tick();
        s_valid = 1'b0; repeat (3) tick();
        checks++;
        if ({s_active, s_idle, s_ops, s_lanes, s_sat} !== {4'd1, 4'd0, 4'd0, 4'd15, 1'b1}) begin
            errors++;
            $display("FAIL sat_clamp: got act=%0d lanes=%0d sat=%b expected 1 15 1", s_active, s_lanes, s_sat);
        end
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; enable = 1'b0;
        idle_inputs();
        s_clear = 1'b0; s_enable = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
        m_max[0] = (longint'(1) << CW) - 1;
        m_max[1] = (longint'(1) << SCW) - 1;
        model_clear(0);
        model_clear(1);
        test_reset();
        test_basic();
        test_random();
        test_snapshot();
        test_clear_retire();
        test_reset_midflight();
        test_disable();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
